// File: rtl/avr_data_ram.sv
// ============================================================================
// Module   : avr_data_ram
// Purpose  : Single-port data RAM with configurable wait states and a
//            req/ready/done handshake; out-of-range accesses are flagged.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avr_data_ram #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 11,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]      c_WS    = 3'(WAIT_STATES);
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              w_accept;
  logic              w_enter_done;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;

  assign ready    = (r_state == IDLE) & ~RST;
  assign done     = (r_state == DONE) & ~RST;
  assign err      = r_err & done;
  assign stall    = (req & ~ready) | (r_state != IDLE);
  assign rdata    = r_rdata;
  assign w_accept = ready & req;

  // With zero wait states the access completes on the acceptance edge itself,
  // so the live inputs are used there instead of the not-yet-latched copies.
  assign w_we       = (r_state == IDLE) ? we    : r_we;
  assign w_addr     = (r_state == IDLE) ? addr  : r_addr;
  assign w_wdata    = (r_state == IDLE) ? wdata : r_wdata;
  assign w_in_range = {1'b0, w_addr} < c_DEPTH;

  assign w_enter_done = (w_next == DONE) & (r_state != DONE) & ~RST;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_cnt_next = c_WS;
          w_next     = (c_WS != 3'd0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (w_enter_done) begin
        r_err <= ~w_in_range;
        if (!w_we) begin
          r_rdata <= w_in_range ? mem[w_addr] : '0;
        end
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive RST.
  always_ff @(posedge CLK) begin
    if (w_enter_done && w_we && w_in_range) begin
      mem[w_addr] <= w_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avr_data_ram.sv
// ============================================================================
// Module   : tb_avr_data_ram
// Purpose  : Directed self-checking bench; instance k runs with WAIT_STATES=k.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avr_data_ram;

  logic        clk = 1'b0;
  logic [3:0]  rst = 4'hF;
  logic [3:0]  req = '0;
  logic [3:0]  we  = '0;
  logic [10:0] addr  [4];
  logic [7:0]  wdata [4];
  logic [3:0]  ready, done, err, stall;
  logic [7:0]  rdata [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0 has a reduced depth so the top of the address space is unmapped.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    avr_data_ram #(
      .DATA_W(8), .ADDR_W(11), .DEPTH((g == 0) ? 1536 : 2048), .WAIT_STATES(g)
    ) u_dut (
      .CLK(clk), .RST(rst[g]), .req(req[g]), .we(we[g]), .addr(addr[g]),
      .wdata(wdata[g]), .ready(ready[g]), .done(done[g]), .rdata(rdata[g]),
      .err(err[g]), .stall(stall[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge, ends at the negedge of the cycle after done.
  task automatic access(input int k, input logic w, input logic [10:0] a,
                        input logic [7:0] d, output int lat,
                        output logic e, output logic [7:0] rd);
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    chk("accept_ready", 32'(ready[k]), 1);
    @(posedge clk); #1;
    req[k] = 1'b0; we[k] = ~w; addr[k] = ~a; wdata[k] = ~d;
    lat = -1; e = 1'b0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done[k]) begin
        lat = i; e = err[k]; rd = rdata[k];
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done[k]), 0);
    chk("ready_after_done", 32'(ready[k]), 1);
  endtask

  initial begin
    int         lat;
    logic       e;
    logic [7:0] rd;
    for (int i = 0; i < 4; i++) begin addr[i] = '0; wdata[i] = '0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready[0]), 0);
    chk("rst_done",  32'(done[0]), 0);
    chk("rst_err",   32'(err[0]), 0);
    chk("rst_rdata", 32'(rdata[3]), 0);
    @(posedge clk); #1;
    rst = '0;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready), 32'hF);

    // Zero wait states: write then immediate read-back.
    access(0, 1'b1, 11'h010, 8'hA5, lat, e, rd);
    chk("ws0_wr_lat", 32'(lat), 1);
    chk("ws0_wr_err", 32'(e), 0);
    access(0, 1'b0, 11'h010, 8'h00, lat, e, rd);
    chk("ws0_rd_lat", 32'(lat), 1);
    chk("ws0_rd_data", 32'(rd), 32'hA5);
    chk("ws0_rd_err", 32'(e), 0);

    // Out-of-range accesses on the 1536-word instance.
    access(0, 1'b1, 11'h7FF, 8'h3C, lat, e, rd);
    chk("oor_wr_err", 32'(e), 1);
    access(0, 1'b0, 11'h7FF, 8'h00, lat, e, rd);
    chk("oor_rd_err", 32'(e), 1);
    chk("oor_rd_data", 32'(rd), 0);
    access(0, 1'b0, 11'h5FF, 8'h00, lat, e, rd);
    chk("top_rd_err", 32'(e), 0);
    chk("top_rd_data", 32'(rd), 0);

    // Three wait states: power-up read, per-cycle stall/ready profile.
    @(posedge clk); #1;
    req[3] = 1'b1; we[3] = 1'b0; addr[3] = 11'h000;
    @(negedge clk);
    chk("ws3_acc_stall", 32'(stall[3]), 0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      req[3] = 1'b0;
      @(negedge clk);
      chk("ws3_stall", 32'(stall[3]), 1);
      chk("ws3_ready", 32'(ready[3]), 0);
      chk("ws3_done", 32'(done[3]), (i == 4) ? 1 : 0);
    end
    chk("ws3_rdata", 32'(rdata[3]), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ws3_ready_after", 32'(ready[3]), 1);
    chk("ws3_stall_after", 32'(stall[3]), 0);

    // Inputs thrashed during WAIT, with req held, must not disturb the write.
    @(posedge clk); #1;
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 11'h040; wdata[3] = 8'h5A;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      req[3] = (i < 4); we[3] = 1'b1;
      addr[3] = 11'(11'h040 + i); wdata[3] = 8'(8'h10 + i);
      @(negedge clk);
      chk("thrash_done", 32'(done[3]), (i == 4) ? 1 : 0);
    end
    access(3, 1'b0, 11'h040, 8'h00, lat, e, rd);
    chk("thrash_rd_040", 32'(rd), 32'h5A);
    access(3, 1'b0, 11'h041, 8'h00, lat, e, rd);
    chk("thrash_rd_041", 32'(rd), 0);

    // Two wait states: reset during WAIT aborts the write.
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 11'h020; wdata[2] = 8'h77;
    @(negedge clk);
    chk("abort_acc_ready", 32'(ready[2]), 1);
    @(posedge clk); #1;
    req[2] = 1'b0; rst[2] = 1'b1;
    @(negedge clk);
    chk("abort_rst_done", 32'(done[2]), 0);
    chk("abort_rst_ready", 32'(ready[2]), 0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done[2]), 0);
      @(posedge clk); #1;
    end
    access(2, 1'b0, 11'h020, 8'h00, lat, e, rd);
    chk("abort_rd_lat", 32'(lat), 3);
    chk("abort_rd_data", 32'(rd), 0);

    // One wait state, req held high, alternating write/read.
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req[1] = 1'b1;
      we[1] = ((c / 3) % 2 == 0);
      addr[1] = 11'h100;
      wdata[1] = 8'(8'h11 * (c / 3 + 1));
      @(negedge clk);
      chk("hold_ready", 32'(ready[1]), (c % 3 == 0) ? 1 : 0);
      chk("hold_stall", 32'(stall[1]), (c % 3 == 0) ? 0 : 1);
      chk("hold_done",  32'(done[1]), (c % 3 == 2) ? 1 : 0);
      if (c == 5)  chk("hold_rd1", 32'(rdata[1]), 32'h11);
      if (c == 11) chk("hold_rd3", 32'(rdata[1]), 32'h33);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
